// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants, working-state payload, FSM encoding and bit-mixing functions.
package sha256_pkg;

   localparam int unsigned WORD_W     = 32;
   localparam int unsigned BLOCK_W    = 512;
   localparam int unsigned DIGEST_W   = 256;
   localparam int unsigned CNT_W      = 6;
   localparam int unsigned NUM_ROUNDS = 64;
   localparam int unsigned WIN_WORDS  = 16;

   // Controller state encoding: IDLE, ROUND, FINAL, DONE
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ROUND = 2'd1;
   localparam logic [1:0] ST_FINAL = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   // Working variables a..h; a sits in the top word so the packed form matches H0..H7 order
   typedef struct packed {
      logic [WORD_W-1:0] a;
      logic [WORD_W-1:0] b;
      logic [WORD_W-1:0] c;
      logic [WORD_W-1:0] d;
      logic [WORD_W-1:0] e;
      logic [WORD_W-1:0] f;
      logic [WORD_W-1:0] g;
      logic [WORD_W-1:0] h;
   } sha_state_t;

   localparam logic [WORD_W-1:0] K [NUM_ROUNDS] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
      32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
      32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
      32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
      32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
      32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
      32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
      32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
      32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   localparam logic [WORD_W-1:0] IV [8] = '{
      32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
   };

   function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x, input int unsigned n);
      return (x >> n) | (x << (WORD_W - n));
   endfunction

   function automatic logic [WORD_W-1:0] sigma0(input logic [WORD_W-1:0] x);
      return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
   endfunction

   function automatic logic [WORD_W-1:0] sigma1(input logic [WORD_W-1:0] x);
      return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
   endfunction

   function automatic logic [WORD_W-1:0] bsigma0(input logic [WORD_W-1:0] x);
      return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
   endfunction

   function automatic logic [WORD_W-1:0] bsigma1(input logic [WORD_W-1:0] x);
      return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
   endfunction

   function automatic sha_state_t iv_state();
      return sha_state_t'({IV[0], IV[1], IV[2], IV[3], IV[4], IV[5], IV[6], IV[7]});
   endfunction

   // Word-wise wrapping add used for the chaining update
   function automatic sha_state_t add_state(input sha_state_t x, input sha_state_t y);
      return sha_state_t'({x.a + y.a, x.b + y.b, x.c + y.c, x.d + y.d,
                           x.e + y.e, x.f + y.f, x.g + y.g, x.h + y.h});
   endfunction

endpackage

// File: rtl/sha256_msg_sched.sv
// 16-word message schedule window; w_t is the word consumed by the current round.
module sha256_msg_sched
   import sha256_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               load,
   input  logic               shift,
   input  logic [BLOCK_W-1:0] block_in,
   output logic [WORD_W-1:0]  w_t
);

   logic [WORD_W-1:0] w_q [WIN_WORDS];
   logic [WORD_W-1:0] w_new_c;

   // W[t] = s1(W[t-2]) + W[t-7] + s0(W[t-15]) + W[t-16], window holds W[t-16..t-1]
   assign w_new_c = sigma1(w_q[14]) + w_q[9] + sigma0(w_q[1]) + w_q[0];
   assign w_t     = w_q[0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < WIN_WORDS; i++) w_q[i] <= '0;
      end else if (load) begin
         for (int i = 0; i < WIN_WORDS; i++) w_q[i] <= block_in[BLOCK_W-1-WORD_W*i -: WORD_W];
      end else if (shift) begin
         for (int i = 0; i < WIN_WORDS-1; i++) w_q[i] <= w_q[i+1];
         w_q[WIN_WORDS-1] <= w_new_c;
      end
   end

endmodule

// File: rtl/sha256_single_iteration.sv
// One combinational SHA-256 compression round.
module sha256_single_iteration
   import sha256_pkg::*;
(
   input  sha_state_t        st,
   input  logic [WORD_W-1:0] w,
   input  logic [WORD_W-1:0] k,
   output sha_state_t        st_c
);

   logic [WORD_W-1:0] t1_c;
   logic [WORD_W-1:0] t2_c;

   always_comb begin
      t1_c = st.h + bsigma1(st.e) + ((st.e & st.f) ^ (~st.e & st.g)) + k + w;
      t2_c = bsigma0(st.a) + ((st.a & st.b) ^ (st.a & st.c) ^ (st.b & st.c));
      st_c   = st;
      st_c.a = t1_c + t2_c;
      st_c.b = st.a;
      st_c.c = st.b;
      st_c.d = st.c;
      st_c.e = st.d + t1_c;
      st_c.f = st.e;
      st_c.g = st.f;
      st_c.h = st.g;
   end

endmodule

// File: rtl/sha256_block_ctrl.sv
// Block-at-a-time SHA-256 controller: 64 rounds at one per clock, chaining value kept across blocks.
module sha256_block_ctrl
   import sha256_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [BLOCK_W-1:0]  block_in,
   input  logic                in_first,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [DIGEST_W-1:0] hash_out,
   output logic                busy
);

   logic [1:0]        state_q, state_nxt;
   logic [CNT_W-1:0]  cnt_q, cnt_nxt;
   sha_state_t        v_q, v_nxt;
   sha_state_t        h_q, h_nxt;
   sha_state_t        round_c;
   logic [WORD_W-1:0] w_t;
   logic              sched_load_c;
   logic              sched_shift_c;

   sha256_msg_sched u_sched (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (sched_load_c),
      .shift    (sched_shift_c),
      .block_in (block_in),
      .w_t      (w_t)
   );

   sha256_single_iteration u_round (
      .st   (v_q),
      .w    (w_t),
      .k    (K[cnt_q]),
      .st_c (round_c)
   );

   assign hash_out = DIGEST_W'(h_q);

   // Next-state and datapath control
   always_comb begin
      state_nxt     = state_q;
      cnt_nxt       = cnt_q;
      v_nxt         = v_q;
      h_nxt         = h_q;
      sched_load_c  = 1'b0;
      sched_shift_c = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (in_valid && in_ready) begin
               sched_load_c = 1'b1;
               cnt_nxt      = '0;
               state_nxt    = ST_ROUND;
               if (in_first) begin
                  h_nxt = iv_state();
                  v_nxt = iv_state();
               end else begin
                  v_nxt = h_q;
               end
            end
         end
         ST_ROUND: begin
            v_nxt         = round_c;
            sched_shift_c = 1'b1;
            cnt_nxt       = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(NUM_ROUNDS - 1)) state_nxt = ST_FINAL;
         end
         ST_FINAL: begin
            h_nxt     = add_state(h_q, v_q);
            state_nxt = ST_DONE;
         end
         ST_DONE: begin
            if (out_ready) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Status flags are registered copies of the next-state decode
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         v_q       <= '0;
         h_q       <= iv_state();
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         state_q   <= state_nxt;
         cnt_q     <= cnt_nxt;
         v_q       <= v_nxt;
         h_q       <= h_nxt;
         in_ready  <= (state_nxt == ST_IDLE);
         out_valid <= (state_nxt == ST_DONE);
         busy      <= (state_nxt == ST_ROUND) || (state_nxt == ST_FINAL);
      end
   end

endmodule

// File: tb/tb_sha256_block_ctrl.sv
// Directed known-answer bench for sha256_block_ctrl: table of blocks plus reset/backpressure sequences.
module tb_sha256_block_ctrl;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_first = 1'b0;
   logic         out_ready = 1'b1;
   logic [511:0] block_in = '0;
   logic         in_ready;
   logic         out_valid;
   logic         busy;
   logic [255:0] hash_out;

   localparam logic [255:0] IV_H  = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
   localparam logic [255:0] ABC_H = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
   localparam logic [255:0] EMP_H = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
   localparam logic [255:0] TWO_H = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

   localparam logic [511:0] ABC_B = {32'h61626380, 448'h0, 32'h00000018};
   localparam logic [511:0] EMP_B = {32'h80000000, 480'h0};
   localparam logic [511:0] TW1_B = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                     32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                     32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                     32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
   localparam logic [511:0] TW2_B = {480'h0, 32'h000001c0};

   sha256_block_ctrl dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .block_in  (block_in),
      .in_first  (in_first),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .hash_out  (hash_out),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   int nvec = 0;
   int nerr = 0;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [511:0] blk;
      logic         first;
      logic         chk_hash;
      logic [255:0] exp;
      int           hold;
      logic         poke;
   } vec_t;

   vec_t tbl[5];

   // Sends one block at a negedge and follows it through to the output handshake
   task automatic run_vec(input vec_t v, input int idx);
      int cyc;
      int wt;
      wt = 0;
      while (!in_ready && wt < 200) begin
         @(negedge clk);
         wt++;
      end
      chk($sformatf("v%0d in_ready before accept", idx), 256'(in_ready), 256'(1));
      in_valid  = 1'b1;
      block_in  = v.blk;
      in_first  = v.first;
      out_ready = (v.hold == 0);
      @(negedge clk);
      in_valid = 1'b0;
      block_in = {16{$urandom()}};
      in_first = ~v.first;
      cyc = 0;
      while (!out_valid && cyc < 200) begin
         if (cyc == 1) begin
            chk($sformatf("v%0d busy in ROUND", idx), 256'({busy, in_ready}), 256'(2'b10));
         end
         in_valid = (v.poke && cyc == 10);
         @(negedge clk);
         cyc++;
      end
      in_valid = 1'b0;
      chk($sformatf("v%0d latency", idx), 256'(cyc), 256'(65));
      if (v.chk_hash) chk($sformatf("v%0d digest", idx), hash_out, v.exp);
      for (int i = 0; i < v.hold; i++) begin
         @(negedge clk);
         chk($sformatf("v%0d hold flags c%0d", idx, i), 256'({out_valid, in_ready, busy}), 256'(3'b100));
         if (v.chk_hash) chk($sformatf("v%0d hold digest c%0d", idx, i), hash_out, v.exp);
      end
      out_ready = 1'b1;
      @(negedge clk);
      chk($sformatf("v%0d after handshake", idx), 256'({out_valid, in_ready}), 256'(2'b01));
   endtask

   initial begin
      tbl[0] = '{blk: ABC_B, first: 1'b1, chk_hash: 1'b1, exp: ABC_H, hold: 0,  poke: 1'b0};
      tbl[1] = '{blk: EMP_B, first: 1'b1, chk_hash: 1'b1, exp: EMP_H, hold: 20, poke: 1'b1};
      tbl[2] = '{blk: TW1_B, first: 1'b1, chk_hash: 1'b0, exp: '0,    hold: 0,  poke: 1'b0};
      tbl[3] = '{blk: TW2_B, first: 1'b0, chk_hash: 1'b1, exp: TWO_H, hold: 0,  poke: 1'b1};
      tbl[4] = '{blk: ABC_B, first: 1'b1, chk_hash: 1'b1, exp: ABC_H, hold: 3,  poke: 1'b0};

      // Power-on reset values
      #12;
      chk("reset flags", 256'({out_valid, in_ready, busy}), 256'(3'b010));
      chk("reset hash", hash_out, IV_H);
      @(negedge clk);
      rst_n = 1'b1;

      // Asynchronous reset in the middle of ROUND
      in_valid = 1'b1;
      block_in = ABC_B;
      in_first = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (20) @(negedge clk);
      chk("mid-round busy", 256'({busy, in_ready, out_valid}), 256'(3'b100));
      #2;
      rst_n = 1'b0;
      #1;
      chk("async reset flags", 256'({out_valid, in_ready, busy}), 256'(3'b010));
      chk("async reset hash", hash_out, IV_H);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 5; i++) run_vec(tbl[i], i);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
